// File: rtl/flash_program_sequencer.sv
// Programmable LED thermometer sequencer: walks a stored table of (hi, lo) bounds.
// Optional freeze input enabled by defining FLASHER_PAUSE_EN.
module flash_program_sequencer #(
   parameter int STEPS    = 6,
   parameter int PRESCALE = 4,
   parameter int FLICK_PT = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [4:0]  cfg_hi,
   input  logic [4:0]  cfg_lo,
   input  logic        cfg_len_we,
   input  logic [2:0]  cfg_len,
   input  logic        start,
   input  logic        flick,
`ifdef FLASHER_PAUSE_EN
   input  logic        pause,
`endif
   output logic [15:0] LED,
   output logic        busy,
   output logic        done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
   localparam logic [3:0]    LP_STEPS = 4'(STEPS);
   localparam logic [4:0]    LP_FLICK = 5'(FLICK_PT);

   typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

   state_t          r_state, w_state_nxt;
   logic [4:0]      r_count, w_count_nxt;
   logic [2:0]      r_idx, w_idx_nxt;
   logic [PW-1:0]   r_pre, w_pre_nxt;
   logic            r_busy, w_busy_nxt;
   logic            r_done, w_done_nxt;
   logic [15:0]     r_led;
   logic [3:0]      r_len;
   logic [4:0]      r_hi [STEPS];
   logic [4:0]      r_lo [STEPS];

   logic            w_pause;
   logic            w_tick;
   logic            w_last;
   logic            w_flick_ok;
   logic            w_idle;
   logic            w_tbl_wr;
   logic [4:0]      w_hi_cur;
   logic [4:0]      w_lo_cur;
   logic [4:0]      w_hi_clip;
   logic [4:0]      w_lo_clip;
   logic [3:0]      w_len_clip;

`ifdef FLASHER_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   function automatic logic [4:0] f_clip16(input logic [4:0] v);
      return (v > 5'd16) ? 5'd16 : v;
   endfunction

   function automatic logic [15:0] f_therm(input logic [4:0] c);
      logic [16:0] t;
      t = (17'd1 << c) - 17'd1;
      return t[15:0];
   endfunction

   assign w_idle     = (r_state == S_IDLE);
   assign w_tbl_wr   = cfg_we && w_idle && ({1'b0, cfg_addr} < LP_STEPS);
   assign w_hi_clip  = f_clip16(cfg_hi);
   assign w_lo_clip  = f_clip16(cfg_lo);
   assign w_len_clip = (cfg_len == 3'd0) ? 4'd1 :
                       (({1'b0, cfg_len} > LP_STEPS) ? LP_STEPS : {1'b0, cfg_len});

   assign w_hi_cur   = r_hi[r_idx];
   assign w_lo_cur   = r_lo[r_idx];
   assign w_tick     = (r_pre == PRE_MAX);
   assign w_last     = ({1'b0, r_idx} == (r_len - 4'd1));
   // Re-climb is only offered at the bottom or the flick point, and never on the final step.
   assign w_flick_ok = flick && !w_last && ((r_count == 5'd0) || (r_count == LP_FLICK));

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_idx_nxt   = r_idx;
      w_pre_nxt   = r_pre;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      if (!w_pause) begin
         case (r_state)
            S_IDLE: begin
               w_pre_nxt = '0;
               if (start || flick) begin
                  w_state_nxt = S_UP;
                  w_idx_nxt   = 3'd0;
                  w_count_nxt = 5'd0;
                  w_busy_nxt  = 1'b1;
               end
            end
            S_UP: begin
               w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
               if (w_tick) begin
                  if (r_count < w_hi_cur) w_count_nxt = r_count + 5'd1;
                  else                    w_state_nxt = S_DOWN;
               end
            end
            S_DOWN: begin
               w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
               // An accepted flick discards a coincident tick.
               if (w_flick_ok) begin
                  w_state_nxt = S_UP;
                  w_pre_nxt   = '0;
               end else if (w_tick) begin
                  if (r_count > w_lo_cur) begin
                     w_count_nxt = r_count - 5'd1;
                  end else if (w_last) begin
                     w_state_nxt = S_IDLE;
                     w_count_nxt = 5'd0;
                     w_idx_nxt   = 3'd0;
                     w_pre_nxt   = '0;
                     w_busy_nxt  = 1'b0;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_idx_nxt   = r_idx + 3'd1;
                     w_state_nxt = S_UP;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_count_nxt = 5'd0;
               w_idx_nxt   = 3'd0;
               w_pre_nxt   = '0;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= 5'd0;
         r_idx   <= 3'd0;
         r_pre   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_led   <= 16'h0000;
         r_len   <= 4'd3;
         for (int i = 0; i < STEPS; i++) begin
            r_hi[i] <= 5'd0;
            r_lo[i] <= 5'd0;
         end
         r_hi[0] <= 5'd16;
         r_lo[0] <= 5'd0;
         r_hi[1] <= 5'd11;
         r_lo[1] <= 5'd5;
         r_hi[2] <= 5'd6;
         r_lo[2] <= 5'd0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_idx   <= w_idx_nxt;
         r_pre   <= w_pre_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_led   <= f_therm(w_count_nxt);
         if (w_tbl_wr) begin
            r_hi[cfg_addr] <= w_hi_clip;
            r_lo[cfg_addr] <= w_lo_clip;
         end
         if (cfg_len_we && w_idle) r_len <= w_len_clip;
      end
   end

   assign LED  = r_led;
   assign busy = r_busy;
   assign done = r_done;

endmodule
